// File: rtl/frame_writer.sv
// Frame writer: accepts one filtered pixel frame per start pulse and streams it into a BRAM write port.
// Optional ping-pong banking enabled by defining FRAME_WRITER_PINGPONG_EN.
module frame_writer #(
   parameter int unsigned IMG_WIDTH  = 220,
   parameter int unsigned IMG_HEIGHT = 168,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   input  logic                  pixel_valid,
   input  logic                  line_end,
   input  logic                  frame_end,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  bank_wr,
   output logic                  bank_rdy
);

   localparam int unsigned FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int unsigned COL_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned CNT_W     = $clog2(FRAME_PIX + 1);

   localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(FRAME_PIX);
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(IMG_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(FRAME_PIX);

   typedef enum logic {
      IDLE,
      WRITE
   } state_t;

   state_t                state;
   logic [COL_W-1:0]      col;
   logic [CNT_W-1:0]      pix_cnt;
   logic [ADDR_WIDTH-1:0] row_base;

   logic                  full;
   logic                  line_wrap;
   logic                  line_bad;
   logic [CNT_W-1:0]      cnt_next;

   // row_base tracks bank base + row*IMG_WIDTH so the address is a single add.
   always_comb begin
      full      = (pix_cnt == CNT_FULL);
      line_wrap = line_end || (col == COL_LAST);
      line_bad  = line_end ? (col != COL_LAST) : (col == COL_LAST);
      cnt_next  = full ? pix_cnt : pix_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state    <= IDLE;
         col      <= '0;
         pix_cnt  <= '0;
         row_base <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         bank_wr  <= 1'b0;
         bank_rdy <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         if (done)
            busy <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= WRITE;
                  busy     <= 1'b1;
                  err      <= 1'b0;
                  col      <= '0;
                  pix_cnt  <= '0;
                  row_base <= bank_wr ? BANK1_BASE : '0;
               end
            end

            WRITE: begin
               if (pixel_valid) begin
                  if (!full) begin
                     wr_en   <= 1'b1;
                     wr_data <= pixel_in;
                     wr_addr <= row_base + ADDR_WIDTH'(col);
                     pix_cnt <= pix_cnt + 1'b1;
                  end else begin
                     err <= 1'b1;
                  end

                  if (line_wrap) begin
                     col      <= '0;
                     row_base <= row_base + ROW_STEP;
                  end else begin
                     col <= col + 1'b1;
                  end

                  if (line_bad)
                     err <= 1'b1;

                  if (frame_end) begin
                     if (cnt_next != CNT_FULL)
                        err <= 1'b1;
                     done  <= 1'b1;
                     state <= IDLE;
`ifdef FRAME_WRITER_PINGPONG_EN
                     bank_rdy <= bank_wr;
                     bank_wr  <= ~bank_wr;
`endif
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer (4x3 frame); works with or without FRAME_WRITER_PINGPONG_EN.
module tb_frame_writer;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int DW = 8;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] pixel_in = '0;
   logic          pixel_valid = 1'b0;
   logic          line_end = 1'b0;
   logic          frame_end = 1'b0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy, done, err, bank_wr, bank_rdy;

   frame_writer #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .pixel_in   (pixel_in),
      .pixel_valid(pixel_valid),
      .line_end   (line_end),
      .frame_end  (frame_end),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .bank_wr    (bank_wr),
      .bank_rdy   (bank_rdy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned   edge_n;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          dn;
   } exp_t;

   exp_t          sbq[$];
   int unsigned   edge_cnt = 0;
   int            tests = 0;
   int            fails = 0;
   logic [AW-1:0] base = '0;
   logic          m_bank = 1'b0;
   logic          m_rdy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (wr_en === 1'b1 || done === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_output", {30'd0, wr_en, done}, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("out_cycle", edge_cnt, e.edge_n);
            chk("wr_en", {31'd0, wr_en}, {31'd0, e.we});
            if (e.we) begin
               chk("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
               chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
            end
            chk("done", {31'd0, done}, {31'd0, e.dn});
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic le, input logic fe,
                       input logic we, input logic [AW-1:0] off, input logic dn);
      exp_t e;
      pixel_in    = d;
      pixel_valid = 1'b1;
      line_end    = le;
      frame_end   = fe;
      if (we || dn) begin
         e.edge_n = edge_cnt + 1;
         e.we     = we;
         e.addr   = base + off;
         e.data   = d;
         e.dn     = dn;
         sbq.push_back(e);
      end
      @(negedge clk);
      pixel_valid = 1'b0;
      line_end    = 1'b0;
      frame_end   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic begin_frame();
      base  = m_bank ? AW'(W * H) : '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("err_after_start", {31'd0, err}, 32'd0);
   endtask

   task automatic full_frame(input logic [DW-1:0] d0);
      for (int i = 0; i < W * H; i++)
         send(d0 + DW'(i), (i % W) == W - 1, i == W * H - 1, 1'b1, AW'(i), i == W * H - 1);
      chk("busy_in_done_cycle", {31'd0, busy}, 32'd1);
   endtask

   task automatic end_frame(input string tag);
`ifdef FRAME_WRITER_PINGPONG_EN
      m_rdy  = m_bank;
      m_bank = ~m_bank;
`endif
      chk({tag, "_bank_wr"}, {31'd0, bank_wr}, {31'd0, m_bank});
      chk({tag, "_bank_rdy"}, {31'd0, bank_rdy}, {31'd0, m_rdy});
      chk({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
      chk({tag, "_drained"}, sbq.size(), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
      chk({tag, "_wr_addr"}, {27'd0, wr_addr}, 32'd0);
      chk({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_bank_wr"}, {31'd0, bank_wr}, 32'd0);
      chk({tag, "_bank_rdy"}, {31'd0, bank_rdy}, 32'd0);
   endtask

   initial begin
      #1 rst_n = 1'b1;
      idle(2);
      chk_all_zero("reset");
      rst_n = 1'b0;
      idle(2);
      chk("post_reset_wr_en", {31'd0, wr_en}, 32'd0);

      // nominal frame
      begin_frame();
      full_frame(8'h10);
      idle(1);
      chk("nominal_err", {31'd0, err}, 32'd0);
      end_frame("nominal");

      // second frame (bank 1 when ping-pong is enabled)
      begin_frame();
      full_frame(8'h20);
      idle(1);
      chk("frame2_err", {31'd0, err}, 32'd0);
      end_frame("frame2");

      // short line: line_end on 3rd pixel of row 0
      begin_frame();
      send(8'h30, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
      send(8'h31, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0);
      chk("short_err_before", {31'd0, err}, 32'd0);
      send(8'h32, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0);
      chk("short_err_set", {31'd0, err}, 32'd1);
      send(8'h33, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
      send(8'h34, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
      send(8'h35, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
      send(8'h36, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
      send(8'h37, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
      send(8'h38, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
      send(8'h39, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0);
      send(8'h3A, 1'b1, 1'b1, 1'b1, 5'd11, 1'b1);
      idle(1);
      chk("short_err_sticky", {31'd0, err}, 32'd1);
      end_frame("short");

      // overflow: 14 pixels, frame_end on the 14th
      begin_frame();
      for (int i = 0; i < W * H; i++)
         send(8'h40 + DW'(i), (i % W) == W - 1, 1'b0, 1'b1, AW'(i), 1'b0);
      chk("ovf_err_before", {31'd0, err}, 32'd0);
      send(8'h4C, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("ovf_err_set", {31'd0, err}, 32'd1);
      send(8'h4D, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
      chk("ovf_busy_done_cycle", {31'd0, busy}, 32'd1);
      idle(1);
      chk("ovf_err_sticky", {31'd0, err}, 32'd1);
      end_frame("ovf");

      // idle/arm: pixels in IDLE ignored, start in WRITE ignored
      send(8'h50, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("idle_no_write", {31'd0, wr_en}, 32'd0);
      chk("idle_not_busy", {31'd0, busy}, 32'd0);
      base  = m_bank ? AW'(W * H) : '0;
      start = 1'b1;
      send(8'h51, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      start = 1'b0;
      chk("arm_pixel_dropped", {31'd0, wr_en}, 32'd0);
      chk("arm_busy", {31'd0, busy}, 32'd1);
      chk("arm_err_cleared", {31'd0, err}, 32'd0);
      send(8'h52, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
      send(8'h53, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0);
      start = 1'b1;
      idle(1);
      start = 1'b0;
      chk("restart_ignored_busy", {31'd0, busy}, 32'd1);
      for (int off = 2; off < W * H; off++)
         send(8'h52 + DW'(off), (off % W) == W - 1, off == W * H - 1, 1'b1, AW'(off), off == W * H - 1);
      idle(1);
      chk("arm_err", {31'd0, err}, 32'd0);
      end_frame("arm");

      // reset mid-frame after 5 pixels
      begin_frame();
      for (int off = 0; off < 5; off++)
         send(8'h60 + DW'(off), off == W - 1, 1'b0, 1'b1, AW'(off), 1'b0);
      idle(1);
      rst_n = 1'b1;
      #1;
      chk_all_zero("midreset");
      m_bank = 1'b0;
      m_rdy  = 1'b0;
      idle(1);
      rst_n = 1'b0;
      idle(1);
      chk("release_no_write", {31'd0, wr_en}, 32'd0);
      begin_frame();
      full_frame(8'h70);
      idle(1);
      chk("after_reset_err", {31'd0, err}, 32'd0);
      end_frame("after_reset");

      idle(3);
      chk("final_drained", sbq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL provide parameter IMG_WIDTH, default 220, pixels per line.
REQ-002 SHALL provide parameter IMG_HEIGHT, default 168, lines per frame.
REQ-003 SHALL provide parameter DATA_WIDTH, default 8, pixel bits.
REQ-004 SHALL provide parameter ADDR_WIDTH, default 17, BRAM address bits; must cover 2*IMG_WIDTH*IMG_HEIGHT.
REQ-005 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  in  1  arm pulse; accept one frame.
REQ-008 SHALL have ports pixel_in  in  DATA_WIDTH, pixel_valid  in  1, line_end  in  1, frame_end  in  1  filtered pixel stream; line_end/frame_end qualify the last pixel of line/frame, valid only with pixel_valid.
REQ-009 SHALL have ports wr_en  out  1, wr_addr  out  ADDR_WIDTH, wr_data  out  DATA_WIDTH  double-part BRAM write port.
REQ-010 SHALL have ports busy  out  1, done  out  1 (single-cycle pulse), err  out  1 (sticky), bank_wr  out  1 (bank being written), bank_rdy  out  1 (bank holding last complete frame).

Function
REQ-011 SHALL implement states IDLE, WRITE; IDLE->WRITE on start; WRITE->IDLE on the accepted pixel carrying frame_end.
REQ-012 SHALL ignore pixel_valid in IDLE (no write, no count change) and ignore start in WRITE.
REQ-013 SHALL register writes: pixel accepted in cycle N drives wr_en=1, wr_data=pixel_in, wr_addr in cycle N+1; wr_en=0 otherwise.
REQ-014 SHALL compute wr_addr = bank_wr*IMG_WIDTH*IMG_HEIGHT + row*IMG_WIDTH + col via running counters, no multiplier; col, row, address cleared on start.
REQ-015 SHALL increment col per accepted pixel; on line_end set col=0, row=row+1.
REQ-016 SHALL set err if line_end arrives with col != IMG_WIDTH-1, or col reaches IMG_WIDTH-1 without line_end (col wraps to 0, row increments).
REQ-017 SHALL drop (no wr_en) pixels once IMG_WIDTH*IMG_HEIGHT pixels are written, set err, keep WRITE until frame_end.
REQ-018 SHALL set err if frame_end arrives with pixel count != IMG_WIDTH*IMG_HEIGHT; frame still terminates.
REQ-019 SHALL pulse done in the same cycle as the final wr_en (N+1), or cycle N+1 if the frame_end pixel was dropped; busy=1 from the cycle after start through the done cycle.
REQ-020 SHALL, on done, set bank_rdy=bank_wr (frame just written) and update bank_wr per Configuration.
REQ-021 SHALL clear err only on start; start and a simultaneous pixel_valid in IDLE: pixel ignored.

Reset
REQ-022 SHALL, on rst_n=1 at any time including mid-frame, force IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, bank_wr=0, bank_rdy=0, counters=0; no write issued in the reset-release cycle.

Configuration
REQ-023 SHALL honor macro FRAME_WRITER_PINGPONG_EN: defined -> bank_wr toggles on each done, alternating base 0 and IMG_WIDTH*IMG_HEIGHT; undefined -> bank_wr fixed 0, bank_rdy fixed 0, all frames at base 0.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, ADDR_WIDTH=5)
REQ-024 SHALL test nominal frame: start, 12 pixels 0x10..0x1B with correct line_end/frame_end -> wr_addr 0..11 in order, one cycle after each accept, done with last write, err=0.
REQ-025 SHALL test ping-pong (macro defined): two frames -> second frame addresses 12..23, bank_rdy=0 after frame 1, 1 after frame 2, bank_wr back to 0.
REQ-026 SHALL test short line: line_end on 3rd pixel of row 0 -> err=1, next pixel written at addr 4.
REQ-027 SHALL test overflow: 14 pixels, frame_end on 14th -> 12 writes only, err=1, done on cycle after 14th accept.
REQ-028 SHALL test idle/arm: pixel_valid before start -> no wr_en; start during WRITE -> no counter reset.
REQ-029 SHALL test reset mid-frame: rst_n=1 after 5 pixels -> all outputs 0; new start then writes from addr 0.
